// File: rtl/config_byte_transmitter.sv
// config_byte_transmitter
//   Queues host configuration bytes and broadcasts them to trace units.
//   Tracing is dropped, held quiet for QUIESCE_CYCLES, then the queued bytes
//   are streamed out. Each change of target ID is separated by one idle-ID
//   cycle so receivers restart their byte counters. Tracing is restored after
//   one final idle-ID cycle.
//
//   Optional feature: define CFG_TX_BYTE_COUNT_EN to add the bytes_sent
//   counter output.
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous active-high reset
//   cfg_valid    host byte valid
//   cfg_ready    FIFO can accept a byte (FIFO not full)
//   cfg_id       target unit config ID
//   cfg_data     configuration byte
//   cfg_last     final byte of the reconfiguration session
//   tracing      1 = normal tracing, 0 = reconfiguration
//   configId     broadcast target ID (IDLE_ID when nothing is addressed)
//   configData   broadcast byte
//   busy         high in every state except IDLE
//   underrun     sticky: FIFO ran dry mid-session; cleared only by reset
//   bytes_sent   (CFG_TX_BYTE_COUNT_EN only) bytes emitted this session
//
// FSM states
//   state    | meaning
//   IDLE     | tracing on, waiting for a queued byte
//   QUIESCE  | tracing off, idle ID held; last cycle pops the first byte
//   SEND     | showing a byte (or idle ID on underrun); pops same-ID bytes
//   GAP      | idle ID between two target IDs; pops the next unit's byte
//   RESUME   | idle ID one more cycle after the last byte, then tracing on

module config_byte_transmitter #(
   parameter int         FIFO_DEPTH     = 8,
   parameter logic [7:0] IDLE_ID        = 8'hFF,
   parameter int         QUIESCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   input  logic [7:0] cfg_id,
   input  logic [7:0] cfg_data,
   input  logic       cfg_last,
   output logic       tracing,
   output logic [7:0] configId,
   output logic [7:0] configData,
   output logic       busy,
   output logic       underrun
`ifdef CFG_TX_BYTE_COUNT_EN
   ,
   output logic [15:0] bytes_sent
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int QW = (QUIESCE_CYCLES > 1) ? $clog2(QUIESCE_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_QUIESCE,
      S_SEND,
      S_GAP,
      S_RESUME
   } state_t;

   // ---------------------------------------------------------------- FIFO
   logic [7:0] mem_id   [FIFO_DEPTH];
   logic [7:0] mem_data [FIFO_DEPTH];
   logic       mem_last [FIFO_DEPTH];

   // Pointers carry one extra wrap bit to tell full from empty.
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        empty;
   logic        full;
   logic        push;
   logic        pop;
   logic [7:0]  head_id;
   logic [7:0]  head_data;
   logic        head_last;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign cfg_ready = ~full;
   assign push      = cfg_valid & cfg_ready;
   assign head_id   = mem_id[rd_ptr[AW-1:0]];
   assign head_data = mem_data[rd_ptr[AW-1:0]];
   assign head_last = mem_last[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push) begin
         mem_id[wr_ptr[AW-1:0]]   <= cfg_id;
         mem_data[wr_ptr[AW-1:0]] <= cfg_data;
         mem_last[wr_ptr[AW-1:0]] <= cfg_last;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // ---------------------------------------------------------------- FSM
   state_t      state, state_nxt;
   logic [QW-1:0] q_cnt, q_cnt_nxt;
   logic [7:0]  last_id, last_id_nxt;
   logic        done, done_nxt;           // last=1 byte already popped
   logic        tracing_nxt;
   logic [7:0]  config_id_nxt;
   logic [7:0]  config_data_nxt;
   logic        underrun_nxt;

   always_comb begin
      state_nxt       = state;
      q_cnt_nxt       = q_cnt;
      last_id_nxt     = last_id;
      done_nxt        = done;
      underrun_nxt    = underrun;
      tracing_nxt     = 1'b0;
      config_id_nxt   = IDLE_ID;
      config_data_nxt = 8'h00;
      pop             = 1'b0;

      case (state)
         S_IDLE: begin
            tracing_nxt = 1'b1;
            if (!empty) begin
               state_nxt   = S_QUIESCE;
               tracing_nxt = 1'b0;
               q_cnt_nxt   = QW'(QUIESCE_CYCLES - 1);
               done_nxt    = 1'b0;
            end
         end
         S_QUIESCE: begin
            // FIFO cannot be empty here; the first byte needs no gap.
            if (q_cnt != '0) begin
               q_cnt_nxt = q_cnt - QW'(1);
            end else begin
               pop       = 1'b1;
               state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            if (done) begin
               state_nxt = S_RESUME;
            end else if (empty) begin
               underrun_nxt = 1'b1;
            end else if (head_id == last_id) begin
               pop = 1'b1;
            end else begin
               state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            pop       = 1'b1;
            state_nxt = S_SEND;
         end
         S_RESUME: begin
            state_nxt   = S_IDLE;
            tracing_nxt = 1'b1;
         end
         default: begin
            state_nxt   = S_IDLE;
            tracing_nxt = 1'b1;
         end
      endcase

      if (pop) begin
         config_id_nxt   = head_id;
         config_data_nxt = head_data;
         last_id_nxt     = head_id;
         done_nxt        = head_last;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         q_cnt      <= '0;
         last_id    <= IDLE_ID;
         done       <= 1'b0;
         tracing    <= 1'b1;
         configId   <= IDLE_ID;
         configData <= 8'h00;
         busy       <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         state      <= state_nxt;
         q_cnt      <= q_cnt_nxt;
         last_id    <= last_id_nxt;
         done       <= done_nxt;
         tracing    <= tracing_nxt;
         configId   <= config_id_nxt;
         configData <= config_data_nxt;
         busy       <= (state_nxt != S_IDLE);
         underrun   <= underrun_nxt;
      end
   end

`ifdef CFG_TX_BYTE_COUNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bytes_sent <= 16'h0000;
      end else if (state == S_IDLE && state_nxt == S_QUIESCE) begin
         bytes_sent <= 16'h0000;
      end else if (pop && bytes_sent != 16'hFFFF) begin
         bytes_sent <= bytes_sent + 16'h0001;
      end
   end
`endif

endmodule

// File: tb/tb_config_byte_transmitter.sv
// tb_config_byte_transmitter
//   Directed bench. Instance a uses default parameters; instance b uses a
//   long quiesce so its FIFO can be filled before anything is popped.
//   Both share id/data/last and reset but have separate valid strobes.
//   Output streams are logged on every falling edge and compared against
//   hand-written expected sequences starting at the first tracing=0 cycle.

module tb_config_byte_transmitter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cfg_valid_a = 1'b0;
   logic       cfg_valid_b = 1'b0;
   logic [7:0] cfg_id = 8'h00;
   logic [7:0] cfg_data = 8'h00;
   logic       cfg_last = 1'b0;

   logic       cfg_ready_a, cfg_ready_b;
   logic       tracing_a, tracing_b;
   logic [7:0] config_id_a, config_id_b;
   logic [7:0] config_data_a, config_data_b;
   logic       busy_a, busy_b;
   logic       underrun_a, underrun_b;
`ifdef CFG_TX_BYTE_COUNT_EN
   logic [15:0] bytes_sent_a, bytes_sent_b;
`endif

   always #5 clk = ~clk;

   config_byte_transmitter dut_a (
      .clk        (clk),
      .reset      (reset),
      .cfg_valid  (cfg_valid_a),
      .cfg_ready  (cfg_ready_a),
      .cfg_id     (cfg_id),
      .cfg_data   (cfg_data),
      .cfg_last   (cfg_last),
      .tracing    (tracing_a),
      .configId   (config_id_a),
      .configData (config_data_a),
      .busy       (busy_a),
      .underrun   (underrun_a)
`ifdef CFG_TX_BYTE_COUNT_EN
      ,
      .bytes_sent (bytes_sent_a)
`endif
   );

   config_byte_transmitter #(.QUIESCE_CYCLES(10)) dut_b (
      .clk        (clk),
      .reset      (reset),
      .cfg_valid  (cfg_valid_b),
      .cfg_ready  (cfg_ready_b),
      .cfg_id     (cfg_id),
      .cfg_data   (cfg_data),
      .cfg_last   (cfg_last),
      .tracing    (tracing_b),
      .configId   (config_id_b),
      .configData (config_data_b),
      .busy       (busy_b),
      .underrun   (underrun_b)
`ifdef CFG_TX_BYTE_COUNT_EN
      ,
      .bytes_sent (bytes_sent_b)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [16:0] log_a [$];
   logic [16:0] log_b [$];
   logic [16:0] exp_q [$];

   always @(negedge clk) begin
      if (!reset) begin
         log_a.push_back({tracing_a, config_id_a, config_data_a});
         log_b.push_back({tracing_b, config_id_b, config_data_b});
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset       = 1'b1;
      cfg_valid_a = 1'b0;
      cfg_valid_b = 1'b0;
      log_a.delete();
      log_b.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic push(input bit sel, input logic [7:0] id,
                       input logic [7:0] data, input bit last);
      bit ok;
      ok       = 1'b0;
      cfg_id   = id;
      cfg_data = data;
      cfg_last = last;
      if (sel) cfg_valid_b = 1'b1;
      else     cfg_valid_a = 1'b1;
      for (int n = 0; n < 50; n++) begin
         if (sel ? cfg_ready_b : cfg_ready_a) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check("push_ready_timeout", 0, 1);
      @(negedge clk);
      cfg_valid_a = 1'b0;
      cfg_valid_b = 1'b0;
   endtask

   task automatic wait_idle(input bit sel, input string tag);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 300; n++) begin
         if (!(sel ? busy_b : busy_a)) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check({tag, "_idle"}, ok, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic exp_add(input bit tr, input logic [7:0] id,
                          input logic [7:0] data);
      exp_q.push_back({tr, id, data});
   endtask

   task automatic compare_log(input string tag);
      int start;
      start = -1;
      for (int i = 0; i < log_a.size(); i++) begin
         if (!log_a[i][16]) begin
            start = i;
            break;
         end
      end
      check({tag, "_start"}, (start >= 0), 1);
      if (start >= 0) begin
         for (int i = 0; i < exp_q.size(); i++) begin
            if (start + i < log_a.size())
               check($sformatf("%s[%0d]", tag, i), log_a[start+i], exp_q[i]);
            else
               check($sformatf("%s[%0d]", tag, i), 32'hFFFF_FFFF, exp_q[i]);
         end
      end
      exp_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit   found;
      int   cnt;
      logic [7:0] got_bytes [$];

      // ---- reset state
      @(negedge clk);
      check("rst_tracing",  tracing_a,     1);
      check("rst_id",       config_id_a,   8'hFF);
      check("rst_data",     config_data_a, 8'h00);
      check("rst_busy",     busy_a,        0);
      check("rst_underrun", underrun_a,    0);
      check("rst_ready",    cfg_ready_a,   1);

      // ---- single unit, three bytes
      do_reset();
      push(0, 8'h02, 8'hA1, 0);
      push(0, 8'h02, 8'hA2, 0);
      push(0, 8'h02, 8'hA3, 1);
      check("t1_busy", busy_a, 1);
      wait_idle(0, "t1");
      repeat (4) exp_add(0, 8'hFF, 8'h00);
      exp_add(0, 8'h02, 8'hA1);
      exp_add(0, 8'h02, 8'hA2);
      exp_add(0, 8'h02, 8'hA3);
      exp_add(0, 8'hFF, 8'h00);
      exp_add(1, 8'hFF, 8'h00);
      compare_log("t1");
      check("t1_underrun", underrun_a, 0);

      // ---- two units, gap between IDs
      do_reset();
      push(0, 8'h00, 8'h11, 0);
      push(0, 8'h00, 8'h22, 0);
      push(0, 8'h01, 8'h33, 1);
      wait_idle(0, "t2");
      repeat (4) exp_add(0, 8'hFF, 8'h00);
      exp_add(0, 8'h00, 8'h11);
      exp_add(0, 8'h00, 8'h22);
      exp_add(0, 8'hFF, 8'h00);
      exp_add(0, 8'h01, 8'h33);
      exp_add(0, 8'hFF, 8'h00);
      exp_add(1, 8'hFF, 8'h00);
      compare_log("t2");

      // ---- fill the FIFO while instance b is quiescing
      do_reset();
      for (int i = 1; i <= 8; i++) push(1, 8'h05, 8'(i), 0);
      check("t3_ready_full", cfg_ready_b, 0);
      push(1, 8'h05, 8'h09, 1);
      wait_idle(1, "t3");
      got_bytes.delete();
      for (int i = 0; i < log_b.size(); i++) begin
         if (!log_b[i][16] && log_b[i][15:8] != 8'hFF) begin
            got_bytes.push_back(log_b[i][7:0]);
            check($sformatf("t3_id[%0d]", i), log_b[i][15:8], 8'h05);
         end
      end
      check("t3_count", got_bytes.size(), 9);
      for (int i = 0; i < got_bytes.size(); i++)
         check($sformatf("t3_byte[%0d]", i), got_bytes[i], i + 1);

      // ---- underrun mid-session
      do_reset();
      push(0, 8'h03, 8'h41, 0);
      push(0, 8'h03, 8'h42, 0);
      check("t4_underrun_clear", underrun_a, 0);
      found = 1'b0;
      for (int n = 0; n < 30; n++) begin
         if (config_id_a == 8'h03 && config_data_a == 8'h42) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("t4_second_byte_seen", found, 1);
      repeat (3) @(negedge clk);
      check("t4_underrun_set", underrun_a, 1);
      push(0, 8'h03, 8'h43, 0);
      push(0, 8'h03, 8'h44, 1);
      wait_idle(0, "t4");
      repeat (4) exp_add(0, 8'hFF, 8'h00);
      exp_add(0, 8'h03, 8'h41);
      exp_add(0, 8'h03, 8'h42);
      repeat (4) exp_add(0, 8'hFF, 8'h00);
      exp_add(0, 8'h03, 8'h43);
      exp_add(0, 8'h03, 8'h44);
      exp_add(0, 8'hFF, 8'h00);
      exp_add(1, 8'hFF, 8'h00);
      compare_log("t4");
      check("t4_underrun_held", underrun_a, 1);

      // ---- reset during SEND
      do_reset();
      push(0, 8'h07, 8'h01, 0);
      push(0, 8'h07, 8'h02, 0);
      push(0, 8'h07, 8'h03, 0);
      push(0, 8'h07, 8'h04, 1);
      found = 1'b0;
      for (int n = 0; n < 30; n++) begin
         if (config_id_a == 8'h07) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("t5_in_send", found, 1);
      reset = 1'b1;
      #1;
      check("t5_tracing", tracing_a,   1);
      check("t5_id",      config_id_a, 8'hFF);
      check("t5_busy",    busy_a,      0);
      check("t5_ready",   cfg_ready_a, 1);
      log_a.delete();
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      cnt = 0;
      foreach (log_a[i]) if (!log_a[i][16]) cnt++;
      check("t5_no_resume", cnt, 0);
      check("t5_busy_after", busy_a, 0);

`ifdef CFG_TX_BYTE_COUNT_EN
      // ---- byte counter
      do_reset();
      for (int i = 1; i <= 5; i++) push(0, 8'h09, 8'(i), (i == 5));
      wait_idle(0, "t6");
      check("t6_bytes_sent", bytes_sent_a, 16'd5);
      push(0, 8'h09, 8'h10, 1);
      found = 1'b0;
      for (int n = 0; n < 30; n++) begin
         if (!tracing_a) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("t6_quiesce_seen", found, 1);
      check("t6_bytes_cleared", bytes_sent_a, 16'd0);
      wait_idle(0, "t6b");
      check("t6_bytes_one", bytes_sent_a, 16'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
